// File: rtl/sdram_digit_pkg.sv
// sdram_digit_pkg
//   Shared types and defaults for the SDRAM digit write/read paths.
//   - wr_state_e      : writer FSM states
//   - DIGIT_W         : width of one digit word (matches display read width)
//   - DIGIT_DEPTH     : digits per burst (one per 7-segment display)
//   - DIGIT_MAX       : largest legal digit value
//   - SDRAM_BURST_LEN : burst length programmed into the SDRAM controller,
//                       used by both the writer and the display read side
package sdram_digit_pkg;

  localparam int DIGIT_W         = 6;
  localparam int DIGIT_DEPTH     = 4;
  localparam int DIGIT_MAX       = 9;
  localparam int SDRAM_BURST_LEN = DIGIT_DEPTH;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REQ     = 2'd1,
    ST_BURST   = 2'd2,
    ST_DONE    = 2'd3
  } wr_state_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
//   Push-button conditioner: 2-flop synchroniser, DEB_CYC-cycle debounce
//   window and a registered rising-edge pulse of the debounced level.
//   The press pulse appears 2 + DEB_CYC + 1 cycles after a clean raw edge.
// Ports:
//   clk    in   system clock
//   s_rst  in   synchronous active-high reset
//   key    in   raw button, asynchronous, pressed = 1
//   press  out  1-cycle pulse on a debounced rising edge
module key_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic s_rst,
  input  logic key,
  output logic press
);

  localparam int              CNT_W    = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [1:0]       sync;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync     <= {sync[0], key};
      stable_d <= stable;
      press    <= stable & ~stable_d;
      // The counter only runs while the synchronised input disagrees with
      // the stable level; any agreement (a bounce back) restarts it.
      if (sync[1] != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sdram_digit_writer.sv
// sdram_digit_writer
//   Collects DEPTH digit values from slide switches (one per debounced key
//   press) and writes them as one burst at BASE_ADDR through the SDRAM
//   controller's request/ack + data-request handshake.
// Ports:
//   clk          in   system clock
//   s_rst        in   synchronous active-high reset
//   key          in   raw push-button, pressed = 1
//   sw           in   digit value to capture
//   wr_trig      out  write request, held until wr_ack
//   wr_ack       in   controller accepted the request (1-cycle pulse)
//   wr_addr      out  burst start address (constant BASE_ADDR)
//   wr_data_req  in   controller consumes wr_data this cycle
//   wr_data      out  current burst word (buf[0] outside a burst)
//   digit_cnt    out  digits captured so far, 0..DEPTH
//   busy         out  high while requesting or bursting
//   err          out  1-cycle pulse: captured value out of range, rejected
//   done         out  1-cycle pulse after the last beat
module sdram_digit_writer
  import sdram_digit_pkg::*;
#(
  parameter int                DATA_W    = DIGIT_W,
  parameter int                DEPTH     = DIGIT_DEPTH,
  parameter int                ADDR_W    = 22,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEB_CYC   = 500000,
  parameter int                MAX_DIGIT = DIGIT_MAX
) (
  input  logic              clk,
  input  logic              s_rst,
  input  logic              key,
  input  logic [DATA_W-1:0] sw,
  output logic              wr_trig,
  input  logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data_req,
  output logic [DATA_W-1:0] wr_data,
  output logic [2:0]        digit_cnt,
  output logic              busy,
  output logic              err,
  output logic              done
);

  // digit_cnt is 3 bits wide, so DEPTH is limited to 7.
  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]        CNT_FULL = 3'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] MAX_V    = DATA_W'(MAX_DIGIT);

  wr_state_e         state;
  logic [PTR_W-1:0]  ptr;
  logic [DATA_W-1:0] dig_buf [DEPTH];
  logic              press;

  key_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_key (
    .clk   (clk),
    .s_rst (s_rst),
    .key   (key),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (s_rst) begin
      state     <= ST_COLLECT;
      ptr       <= '0;
      digit_cnt <= '0;
      wr_trig   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) dig_buf[i] <= '0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_COLLECT: begin
          // A full buffer wins over a coincident press, so a press arriving
          // the cycle digit_cnt reads DEPTH is dropped, not queued.
          if (digit_cnt == CNT_FULL) begin
            state   <= ST_REQ;
            wr_trig <= 1'b1;
            busy    <= 1'b1;
          end else if (press) begin
            if (sw <= MAX_V) begin
              dig_buf[digit_cnt[PTR_W-1:0]] <= sw;
              digit_cnt                     <= digit_cnt + 3'd1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (wr_ack) begin
            wr_trig <= 1'b0;
            ptr     <= '0;
            state   <= ST_BURST;
          end
        end
        ST_BURST: begin
          // No timeout: the controller may stall wr_data_req indefinitely.
          if (wr_data_req) begin
            if (ptr == PTR_LAST) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              digit_cnt <= '0;
            end else begin
              ptr <= ptr + PTR_W'(1);
            end
          end
        end
        ST_DONE: state <= ST_COLLECT;
        default: state <= ST_COLLECT;
      endcase
    end
  end

  // Buffer contents survive DONE, so the last burst's first word stays
  // visible on wr_data until it is overwritten by a new capture.
  assign wr_data = (state == ST_BURST) ? dig_buf[ptr] : dig_buf[0];
  assign wr_addr = BASE_ADDR;

endmodule

// File: tb/tb_sdram_digit_writer.sv
module tb_sdram_digit_writer;

  localparam int DEB   = 4;
  localparam int HOLD  = DEB + 6;
  localparam int DEPTH = 4;
  localparam int MAXD  = 9;

  logic        clk = 1'b0;
  logic        s_rst = 1'b1;
  logic        key = 1'b0;
  logic [5:0]  sw = '0;
  logic        wr_trig;
  logic        wr_ack = 1'b0;
  logic [21:0] wr_addr;
  logic        wr_data_req = 1'b0;
  logic [5:0]  wr_data;
  logic [2:0]  digit_cnt;
  logic        busy;
  logic        err;
  logic        done;

  sdram_digit_writer #(.DEB_CYC(DEB)) dut (
    .clk         (clk),
    .s_rst       (s_rst),
    .key         (key),
    .sw          (sw),
    .wr_trig     (wr_trig),
    .wr_ack      (wr_ack),
    .wr_addr     (wr_addr),
    .wr_data_req (wr_data_req),
    .wr_data     (wr_data),
    .digit_cnt   (digit_cnt),
    .busy        (busy),
    .err         (err),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: captured digits and how many are pending.
  logic [5:0] exp_buf [DEPTH];
  int         model_cnt = 0;
  int         exp_err = 0;

  // Pulse counters observed at every clock edge.
  int done_seen = 0;
  int err_seen  = 0;
  always @(posedge clk) begin
    if (done === 1'b1) done_seen++;
    if (err === 1'b1) err_seen++;
  end

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = '0;
    model_cnt = 0;
  endtask

  // Clean press and release long enough for the debouncer to settle both ways.
  task automatic press_key(input logic [5:0] v, input bit collecting);
    sw  = v;
    key = 1'b1;
    repeat (HOLD) @(negedge clk);
    key = 1'b0;
    repeat (HOLD) @(negedge clk);
    if (collecting) begin
      if (int'(v) <= MAXD) begin
        if (model_cnt < DEPTH) begin
          exp_buf[model_cnt] = v;
          model_cnt++;
        end
      end else begin
        exp_err++;
      end
    end
  endtask

  // Drives one write transaction and checks it beat by beat.
  task automatic do_burst(input string tag, input int ack_dly, input int stall_at,
                          input int stall_len, input bit rand_stall,
                          input bit press_mid, input int rst_at);
    int n, beat, stalls, done0;
    bit req, pressed;
    n = 0;
    while (wr_trig !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_trig !== 1'b1) begin
      errors++;
      $display("FAIL %s wr_trig: got %b want 1 within 60 cycles", tag, wr_trig);
      return;
    end
    checks++;
    if (busy !== 1'b1 || digit_cnt !== 3'd4 || wr_addr !== 22'd0) begin
      errors++;
      $display("FAIL %s req_state: busy=%b cnt=%0d addr=%0d want 1/4/0", tag, busy, digit_cnt, wr_addr);
    end
    repeat (ack_dly) begin
      @(negedge clk);
      checks++;
      if (wr_trig !== 1'b1) begin
        errors++;
        $display("FAIL %s trig_hold: got %b want 1", tag, wr_trig);
      end
    end
    wr_ack = 1'b1;
    @(negedge clk);
    wr_ack = 1'b0;
    checks++;
    if (wr_trig !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s after_ack: trig=%b busy=%b want 0/1", tag, wr_trig, busy);
    end
    done0 = done_seen;
    beat = 0; stalls = 0; pressed = 0; n = 0;
    while (beat < DEPTH && n < 200) begin
      n++;
      if (rst_at == beat) begin
        s_rst = 1'b1;
        wr_data_req = 1'b0;
        @(negedge clk);
        s_rst = 1'b0;
        model_clear();
        checks++;
        if (busy !== 1'b0 || wr_trig !== 1'b0 || digit_cnt !== 3'd0 || done !== 1'b0 || wr_data !== 6'd0) begin
          errors++;
          $display("FAIL %s reset_abort: busy=%b trig=%b cnt=%0d done=%b data=%0d want 0/0/0/0/0",
                   tag, busy, wr_trig, digit_cnt, done, wr_data);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (done_seen != done0) begin
          errors++;
          $display("FAIL %s no_done: got %0d done pulses want 0", tag, done_seen - done0);
        end
        return;
      end
      if (press_mid && beat == 1 && !pressed) begin
        pressed = 1'b1;
        wr_data_req = 1'b0;
        press_key(6'd7, 1'b0);
        checks++;
        if (digit_cnt !== 3'd4 || wr_data !== exp_buf[1] || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s press_ignored: cnt=%0d data=%0d busy=%b want 4/%0d/1",
                   tag, digit_cnt, wr_data, busy, exp_buf[1]);
        end
      end
      req = 1'b1;
      if (beat == stall_at && stalls < stall_len) begin
        req = 1'b0;
        stalls++;
      end else if (rand_stall && $urandom_range(0, 2) == 0) begin
        req = 1'b0;
      end
      wr_data_req = req;
      checks++;
      if (wr_data !== exp_buf[beat]) begin
        errors++;
        $display("FAIL %s beat%0d: wr_data=%0d want %0d", tag, beat, wr_data, exp_buf[beat]);
      end
      @(negedge clk);
      if (req) beat++;
    end
    wr_data_req = 1'b0;
    checks++;
    if (done !== 1'b1 || digit_cnt !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: done=%b cnt=%0d busy=%b want 1/0/0", tag, done, digit_cnt, busy);
    end
    model_cnt = 0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || wr_data !== exp_buf[0] || done_seen - done0 != 1) begin
      errors++;
      $display("FAIL %s post_done: done=%b data=%0d pulses=%0d want 0/%0d/1",
               tag, done, wr_data, done_seen - done0, exp_buf[0]);
    end
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    repeat (3) @(negedge clk);
    s_rst = 1'b0;
    model_clear();
    checks++;
    if (wr_trig !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: trig=%b busy=%b err=%b done=%b want 0", wr_trig, busy, err, done);
    end
    checks++;
    if (digit_cnt !== 3'd0 || wr_data !== 6'd0 || wr_addr !== 22'd0) begin
      errors++;
      $display("FAIL reset_data: cnt=%0d data=%0d addr=%0d want 0", digit_cnt, wr_data, wr_addr);
    end
  endtask

  task automatic test_basic();
    press_key(6'd3, 1'b1);
    checks++;
    if (digit_cnt !== 3'd1 || wr_data !== 6'd3) begin
      errors++;
      $display("FAIL basic_first: cnt=%0d data=%0d want 1/3", digit_cnt, wr_data);
    end
    press_key(6'd1, 1'b1);
    press_key(6'd4, 1'b1);
    press_key(6'd1, 1'b1);
    do_burst("basic", 2, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_bounce();
    int e0;
    logic [5:0] v;
    e0 = err_seen;
    v = 6'($urandom_range(0, MAXD));
    sw = v;
    for (int i = 0; i < 5; i++) begin
      key = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    checks++;
    if (digit_cnt !== 3'(model_cnt)) begin
      errors++;
      $display("FAIL bounce_none: cnt=%0d want %0d", digit_cnt, model_cnt);
    end
    key = 1'b1;
    repeat (HOLD) @(negedge clk);
    key = 1'b0;
    repeat (HOLD) @(negedge clk);
    exp_buf[model_cnt] = v;
    model_cnt++;
    checks++;
    if (digit_cnt !== 3'(model_cnt) || wr_data !== exp_buf[0] || err_seen != e0) begin
      errors++;
      $display("FAIL bounce_one: cnt=%0d data=%0d errs=%0d want %0d/%0d/0",
               digit_cnt, wr_data, err_seen - e0, model_cnt, exp_buf[0]);
    end
  endtask

  task automatic test_err();
    int e0;
    e0 = err_seen;
    press_key(6'd12, 1'b1);
    checks++;
    if (err_seen - e0 != 1 || digit_cnt !== 3'(model_cnt)) begin
      errors++;
      $display("FAIL err_reject: pulses=%0d cnt=%0d want 1/%0d", err_seen - e0, digit_cnt, model_cnt);
    end
    press_key(6'd9, 1'b1);
    checks++;
    if (err_seen - e0 != 1 || digit_cnt !== 3'(model_cnt)) begin
      errors++;
      $display("FAIL err_max_ok: pulses=%0d cnt=%0d want 1/%0d", err_seen - e0, digit_cnt, model_cnt);
    end
    while (model_cnt < DEPTH) press_key(6'($urandom_range(0, MAXD)), 1'b1);
    do_burst("err_fill", $urandom_range(0, 4), -1, 0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_stall();
    while (model_cnt < DEPTH) press_key(6'($urandom_range(0, MAXD)), 1'b1);
    do_burst("stall", 20, 2, 5, 1'b0, 1'b0, -1);
  endtask

  task automatic test_press_in_burst();
    logic [5:0] v;
    while (model_cnt < DEPTH) press_key(6'($urandom_range(0, MAXD)), 1'b1);
    do_burst("press_burst", 1, -1, 0, 1'b0, 1'b1, -1);
    v = 6'($urandom_range(0, MAXD));
    press_key(v, 1'b1);
    checks++;
    if (digit_cnt !== 3'd1 || wr_data !== v) begin
      errors++;
      $display("FAIL refill_slot0: cnt=%0d data=%0d want 1/%0d", digit_cnt, wr_data, v);
    end
  endtask

  task automatic test_reset_mid_burst();
    while (model_cnt < DEPTH) press_key(6'($urandom_range(0, MAXD)), 1'b1);
    do_burst("rst_mid", 1, -1, 0, 1'b0, 1'b0, 2);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      while (model_cnt < DEPTH) press_key(6'($urandom_range(0, 15)), 1'b1);
      do_burst("random", $urandom_range(0, 5), -1, 0, 1'b1, 1'b0, -1);
    end
    checks++;
    if (err_seen != exp_err) begin
      errors++;
      $display("FAIL err_total: got %0d pulses want %0d", err_seen, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_err();
    test_stall();
    test_press_in_burst();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_digit_writer.md
Name: sdram_digit_writer

Overview:
Write-side counterpart of the SDRAM read/7-segment display path. It collects four 6-bit digit values entered on slide switches, one per debounced key press, and writes them as a 4-word burst through the SDRAM controller's write request/data-request handshake. The display path then reads those same four words back from address BASE_ADDR.

Parameters:
DATA_W, 6, width of one digit word (matches display read data width)
DEPTH, 4, digits per burst (one per display)
ADDR_W, 22, SDRAM word address width
BASE_ADDR, 22'd0, first SDRAM word address of the burst
DEB_CYC, 500000, key debounce window in clk cycles (10 ms at 50 MHz); minimum 2
MAX_DIGIT, 9, largest legal digit value

Ports:
clk  in  1  system clock
s_rst  in  1  reset; one clock, synchronous, active-high
key  in  1  raw push-button, asynchronous, pressed = 1
sw  in  DATA_W  digit value to capture
wr_trig  out  1  write request to SDRAM controller
wr_ack  in  1  controller accepted the request (1-cycle pulse)
wr_addr  out  ADDR_W  burst start address, constant BASE_ADDR
wr_data_req  in  1  controller consumes wr_data this cycle
wr_data  out  DATA_W  current burst word
digit_cnt  out  3  digits captured so far, 0..DEPTH
busy  out  1  high in REQ or BURST
err  out  1  1-cycle pulse: captured value > MAX_DIGIT, rejected
done  out  1  1-cycle pulse after the last beat

Behaviour:
- Reset (synchronous, s_rst=1 at posedge): state=COLLECT, digit_cnt=0, buffer cleared to 0, wr_trig=0, busy=0, err=0, done=0, wr_data=0, debounce counter=0.
- key path: 2-flop synchroniser, then debounce. The stable level updates only after the synchronised input has differed from it for DEB_CYC consecutive cycles; any bounce restarts the count. A rising edge of the stable level produces a 1-cycle press pulse, 2+DEB_CYC+1 cycles after the raw edge.
- COLLECT:
  - On press: if sw <= MAX_DIGIT, write buf[digit_cnt] = sw and increment digit_cnt. Otherwise pulse err and leave digit_cnt unchanged.
  - When digit_cnt becomes DEPTH: go to REQ on the next cycle.
- REQ: wr_trig=1 (registered) until the cycle wr_ack=1 is sampled. In that cycle drop wr_trig, clear ptr, go to BURST. wr_ack seen outside REQ is ignored.
- BURST:
  - wr_data = buf[ptr] at all times.
  - Each cycle with wr_data_req=1, ptr increments.
  - A request on beat ptr=DEPTH-1 moves to DONE.
  - wr_data_req=0 stalls; ptr and wr_data hold, with no timeout.
- DONE (1 cycle): done=1, digit_cnt=0, buffer retained, then back to COLLECT.
- Presses during REQ/BURST/DONE are discarded and are not queued. The debouncer keeps running so that it stays in sync with the key.
- wr_data_req in COLLECT/REQ/DONE is ignored. wr_data shows buf[0] outside BURST.
- Reset mid-burst aborts immediately: wr_trig drops the next edge and captured digits are lost. The controller must tolerate an abandoned burst.
- Simultaneous press and digit_cnt=DEPTH-1 is the normal last capture. REQ starts the cycle after digit_cnt reads DEPTH.
- All outputs are registered except wr_data (a mux of registers) and wr_addr (a constant).

Decomposition:
- Package sdram_digit_pkg: state enum {COLLECT, REQ, BURST, DONE}, DATA_W, DEPTH, MAX_DIGIT defaults, and a shared SDRAM burst-length constant also used by the display/read side.
- One sub-module, key_debounce (synchroniser + DEB_CYC counter + rising-edge pulse), reusable by the display block's key input.

Test Plan:
1. Run sim with DEB_CYC=4. Press with sw=3,1,4,1 (clean presses), then wr_ack 2 cycles after wr_trig and wr_data_req held high 4 cycles → wr_data 3,1,4,1 on consecutive beats, done pulse, digit_cnt=0, wr_addr=0.
2. Bounce key 1-0-1 every 2 cycles for 10 cycles, then hold high → exactly one capture, digit_cnt=1.
3. Press with sw=12 → err pulse, digit_cnt unchanged. Follow with sw=9 → accepted, digit_cnt increments.
4. Enter 4 digits, delay wr_ack 20 cycles, then stall wr_data_req low 5 cycles after beat 2 → wr_trig held until ack, wr_data holds word 2 through the stall, no lost or duplicated beat.
5. Press during BURST → ignored; after done, digit_cnt=0 and the next press fills slot 0.
6. Assert s_rst during BURST after beat 1 → next cycle state=COLLECT, busy=0, wr_trig=0, digit_cnt=0, no done pulse.
